// File: rtl/apb_master_pkg.sv
// Shared types and helpers for the single-channel APB master bridge.
package apb_master_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

    typedef struct packed {
        logic [DEFAULT_DATA_WIDTH-1:0] rdata;
        logic                          slverr;
        logic                          timeout;
    } apb_rsp_t;

    // Only the low address byte matters: it covers buses up to 2048 bits wide.
    function automatic logic is_aligned(input logic [7:0] addr_lo,
                                        input int unsigned data_width);
        logic [7:0] mask;
        mask = 8'((data_width / 8) - 1);
        return (addr_lo & mask) == 8'd0;
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Counts consecutive PREADY-low ACCESS cycles; flags the cycle that exhausts the budget.
module apb_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_bypass
            logic w_unused;
            assign w_unused  = ^{i_clk, i_rst, i_clear, i_en};
            assign o_expired = 1'b0;
        end else begin : g_count
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
            logic [CW-1:0] r_count;

            always_ff @(posedge i_clk) begin
                if (i_rst || i_clear) begin
                    r_count <= '0;
                end else if (i_en && (r_count != LAST)) begin
                    r_count <= r_count + CW'(1);
                end
            end

            // Expires while the last budgeted cycle is itself still waiting.
            assign o_expired = i_en && (r_count == LAST);
        end
    endgenerate

endmodule

// File: rtl/apb_master.sv
// APB master bridge: one command at a time, SETUP/ACCESS sequencing, held response.
module apb_master
    import apb_master_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_slverr,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PSELx,
    output logic                  PENABLE,
    input  logic                  PREADY,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PSLVERR,
    output logic [1:0]            o_dbg_state
);

    localparam logic [1:0] S_IDLE   = 2'(IDLE);
    localparam logic [1:0] S_SETUP  = 2'(SETUP);
    localparam logic [1:0] S_ACCESS = 2'(ACCESS);
    localparam logic [1:0] S_RESP   = 2'(RESP);

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic                  r_pwrite;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_slverr;
    logic                  r_timeout;

    logic w_aligned;
    logic w_accept_apb;
    logic w_wait;
    logic w_expired;

    assign w_aligned    = is_aligned(cmd_addr[7:0], DATA_WIDTH);
    assign w_accept_apb = (r_state == S_IDLE) && cmd_valid && w_aligned;
    assign w_wait       = (r_state == S_ACCESS) && !PREADY;

    apb_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .i_clk     (PCLK),
        .i_rst     (PRESET),
        .i_clear   (w_accept_apb),
        .i_en      (w_wait),
        .o_expired (w_expired)
    );

    // Handshakes: a command transfers on a cycle where cmd_valid && cmd_ready;
    // a response transfers on a cycle where rsp_valid && rsp_ready. Both ready/valid
    // outputs are pure decodes of the registered state.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state   <= S_IDLE;
            r_paddr   <= '0;
            r_pwrite  <= 1'b0;
            r_pwdata  <= '0;
            r_rdata   <= '0;
            r_slverr  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (w_aligned) begin
                            r_paddr  <= cmd_addr;
                            r_pwrite <= cmd_write;
                            r_pwdata <= cmd_wdata;
                            r_state  <= S_SETUP;
                        end else begin
                            r_rdata   <= '0;
                            r_slverr  <= 1'b1;
                            r_timeout <= 1'b0;
                            r_state   <= S_RESP;
                        end
                    end
                end
                S_SETUP: begin
                    r_state <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (PREADY) begin
                        r_rdata   <= (!r_pwrite && !PSLVERR) ? PRDATA : '0;
                        r_slverr  <= PSLVERR;
                        r_timeout <= 1'b0;
                        r_state   <= S_RESP;
                    end else if (w_expired) begin
                        r_rdata   <= '0;
                        r_slverr  <= 1'b1;
                        r_timeout <= 1'b1;
                        r_state   <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = (r_state == S_IDLE);
    assign rsp_valid   = (r_state == S_RESP);
    assign PSELx       = (r_state == S_SETUP) || (r_state == S_ACCESS);
    assign PENABLE     = (r_state == S_ACCESS);
    assign PADDR       = r_paddr;
    assign PWRITE      = r_pwrite;
    assign PWDATA      = r_pwdata;
    assign rsp_rdata   = r_rdata;
    assign rsp_slverr  = r_slverr;
    assign rsp_timeout = r_timeout;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: per-cycle expected timeline built from transaction rules.
module tb_apb_master;

    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int TO   = 16;
    localparam int MAXC = 300;

    logic          PCLK = 1'b0;
    logic          PRESET = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_slverr;
    logic          rsp_timeout;
    logic [AW-1:0] PADDR;
    logic          PWRITE;
    logic [DW-1:0] PWDATA;
    logic          PSELx;
    logic          PENABLE;
    logic          PREADY = 1'b0;
    logic [DW-1:0] PRDATA = '0;
    logic          PSLVERR = 1'b0;
    logic [1:0]    o_dbg_state;

    int cyc   = 0;
    int n_chk = 0;
    int n_err = 0;

    apb_master #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_slverr  (rsp_slverr),
        .rsp_timeout (rsp_timeout),
        .PADDR       (PADDR),
        .PWRITE      (PWRITE),
        .PWDATA      (PWDATA),
        .PSELx       (PSELx),
        .PENABLE     (PENABLE),
        .PREADY      (PREADY),
        .PRDATA      (PRDATA),
        .PSLVERR     (PSLVERR),
        .o_dbg_state (o_dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    // ---------------- expected timeline ----------------
    typedef struct {
        bit          ready;
        bit          psel;
        bit          pen;
        bit          rv;
        bit          chk_rsp;
        logic [31:0] rdata;
        bit          serr;
        bit          tout;
        logic [31:0] paddr;
        logic [31:0] pwdata;
        bit          pwrite;
    } exp_t;

    exp_t tl[MAXC];
    exp_t ce;

    task automatic set_phase(input int c, input bit rdy, input bit ps, input bit pe, input bit rv);
        if (c < MAXC) begin
            tl[c].ready = rdy;
            tl[c].psel  = ps;
            tl[c].pen   = pe;
            tl[c].rv    = rv;
        end
    endtask

    task automatic fill_reset_tail(input int from);
        for (int c = from; c < MAXC; c++) begin
            set_phase(c, 1'b1, 1'b0, 1'b0, 1'b0);
            tl[c].chk_rsp = 1'b1;
            tl[c].rdata   = '0;
            tl[c].serr    = 1'b0;
            tl[c].tout    = 1'b0;
            tl[c].paddr   = '0;
            tl[c].pwdata  = '0;
            tl[c].pwrite  = 1'b0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    // ---------------- scoreboard / compare ----------------
    always @(negedge PCLK) begin
        if (cyc >= 1 && cyc < MAXC) begin
            ce = tl[cyc];
            chk("cmd_ready", 32'(cmd_ready), 32'(ce.ready));
            chk("PSELx",     32'(PSELx),     32'(ce.psel));
            chk("PENABLE",   32'(PENABLE),   32'(ce.pen));
            chk("rsp_valid", 32'(rsp_valid), 32'(ce.rv));
            chk("dbg_state", 32'(o_dbg_state),
                ce.rv ? 32'd3 : ce.pen ? 32'd2 : ce.psel ? 32'd1 : 32'd0);
            chk("PADDR",     PADDR,          ce.paddr);
            chk("PWDATA",    PWDATA,         ce.pwdata);
            chk("PWRITE",    32'(PWRITE),    32'(ce.pwrite));
            if (ce.chk_rsp) begin
                chk("rsp_rdata",   rsp_rdata,          ce.rdata);
                chk("rsp_slverr",  32'(rsp_slverr),    32'(ce.serr));
                chk("rsp_timeout", 32'(rsp_timeout),   32'(ce.tout));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int waits, input bit perr, input logic [31:0] prd,
                          input int hold, input bit junk,
                          input int lit_lat, input logic [31:0] lit_rdata,
                          input bit lit_serr, input bit lit_tout);
        int a, t, n, r0;
        bit aligned, tout, ms;
        logic [31:0] mr;
        a       = cyc;
        aligned = (addr % (DW / 8)) == 0;
        t       = a + 1;
        tout    = 1'b0;
        n       = 0;
        if (aligned) begin
            set_phase(t, 1'b0, 1'b1, 1'b0, 1'b0);
            t++;
            if (waits >= TO) begin
                n    = TO;
                tout = 1'b1;
            end else begin
                n = waits + 1;
            end
            for (int i = 0; i < n; i++) begin
                set_phase(t, 1'b0, 1'b1, 1'b1, 1'b0);
                t++;
            end
            for (int c = a + 1; c < MAXC; c++) begin
                tl[c].paddr  = addr;
                tl[c].pwdata = wdata;
                tl[c].pwrite = wr;
            end
            if (tout) begin
                mr = '0;
                ms = 1'b1;
            end else begin
                ms = perr;
                mr = (!wr && !perr) ? prd : 32'd0;
            end
        end else begin
            mr = '0;
            ms = 1'b1;
        end
        r0 = t;
        for (int j = 0; j <= hold; j++) begin
            set_phase(t, 1'b0, 1'b0, 1'b0, 1'b1);
            if (t < MAXC) begin
                tl[t].chk_rsp = 1'b1;
                tl[t].rdata   = mr;
                tl[t].serr    = ms;
                tl[t].tout    = tout;
            end
            t++;
        end
        for (int c = t; c < MAXC; c++) tl[c].chk_rsp = 1'b0;
        chk("model_latency", 32'(r0 - a), 32'(lit_lat));

        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        step();
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom_range(0, 1));
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        if (aligned) begin
            PREADY = 1'b1;
            step();
            for (int i = 0; i < n; i++) begin
                PREADY  = !tout && (i == n - 1);
                PSLVERR = PREADY ? perr : 1'($urandom_range(0, 1));
                PRDATA  = PREADY ? prd : $urandom;
                step();
            end
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
        end
        for (int j = 0; j <= hold; j++) begin
            if (j == 0) begin
                chk("lit_rsp_valid",   32'(rsp_valid),   32'd1);
                chk("lit_rsp_rdata",   rsp_rdata,        lit_rdata);
                chk("lit_rsp_slverr",  32'(rsp_slverr),  32'(lit_serr));
                chk("lit_rsp_timeout", 32'(rsp_timeout), 32'(lit_tout));
            end
            rsp_ready = (j == hold);
            cmd_valid = junk;
            cmd_write = 1'b1;
            cmd_addr  = 32'h0000_0040;
            step();
        end
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
    endtask

    task automatic reset_mid(input logic [31:0] addr, input logic [31:0] wdata);
        int a;
        a = cyc;
        set_phase(a + 1, 1'b0, 1'b1, 1'b0, 1'b0);
        set_phase(a + 2, 1'b0, 1'b1, 1'b1, 1'b0);
        set_phase(a + 3, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int c = a + 1; c < MAXC; c++) begin
            tl[c].paddr  = addr;
            tl[c].pwdata = wdata;
            tl[c].pwrite = 1'b1;
        end
        fill_reset_tail(a + 4);

        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        step();
        cmd_valid = 1'b0;
        PREADY    = 1'b0;
        step();
        step();
        PRESET = 1'b1;
        step();
        PRESET = 1'b0;
        chk("lit_reset_psel",  32'(PSELx), 32'd0);
        chk("lit_reset_paddr", PADDR,      32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        fill_reset_tail(0);
        step();
        step();
        PRESET = 1'b0;
        step();

        do_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0,   1'b0, 32'h0,         0, 1'b0, 3,  32'h0,         1'b0, 1'b0);
        do_txn(1'b0, 32'h0000_0010, 32'h0,         3,   1'b0, 32'h1234_5678, 0, 1'b0, 6,  32'h1234_5678, 1'b0, 1'b0);
        do_txn(1'b0, 32'h0000_0002, 32'h0,         0,   1'b0, 32'hFFFF_FFFF, 0, 1'b0, 1,  32'h0,         1'b1, 1'b0);
        do_txn(1'b0, 32'h0000_0020, 32'h0,         100, 1'b0, 32'h0000_0055, 0, 1'b0, 18, 32'h0,         1'b1, 1'b1);
        do_txn(1'b1, 32'h0000_0024, 32'h0BAD_F00D, 0,   1'b1, 32'h0000_0077, 5, 1'b1, 3,  32'h0,         1'b1, 1'b0);
        do_txn(1'b0, 32'h0000_0028, 32'h0,         1,   1'b0, 32'hCAFE_F00D, 1, 1'b0, 4,  32'hCAFE_F00D, 1'b0, 1'b0);
        do_txn(1'b0, 32'h0000_002C, 32'h0,         2,   1'b1, 32'h9999_9999, 0, 1'b0, 5,  32'h0,         1'b1, 1'b0);
        do_txn(1'b0, 32'h0000_0030, 32'h0,         15,  1'b0, 32'hA5A5_A5A5, 2, 1'b1, 18, 32'hA5A5_A5A5, 1'b0, 1'b0);
        do_txn(1'b1, 32'h0000_0001, 32'h1111_1111, 0,   1'b0, 32'h0,         0, 1'b0, 1,  32'h0,         1'b1, 1'b0);
        reset_mid(32'h0000_0044, 32'h1357_2468);
        step();
        do_txn(1'b1, 32'h0000_0048, 32'h2468_ACE0, 1,   1'b0, 32'h0,         0, 1'b0, 4,  32'h0,         1'b0, 1'b0);

        step();
        step();
        step();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #50000;
        n_err++;
        $display("FAIL watchdog: got no end of sequence, required completion by 50000 ns");
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $fatal(1);
    end

endmodule
